// File: rtl/pla_seq_pkg.sv
// Shared widths, reset state and PLA field positions
// for the PLA-driven FSM sequencer.
package pla_seq_pkg;

  localparam int P_STATE_W = 7;
  localparam int P_SYM_W   = 2;
  localparam int P_OUT_W   = 2;
  localparam int P_CNT_W   = 16;

  localparam logic [P_STATE_W-1:0] P_RESET_STATE = 7'b000_0001;

  localparam int X_SYM_LSB   = 0;
  localparam int X_STATE_LSB = P_SYM_W;
  localparam int Z_SYM_LSB   = 0;
  localparam int Z_STATE_LSB = P_OUT_W;

  localparam int X_W = P_STATE_W + P_SYM_W;
  localparam int Z_W = P_STATE_W + P_OUT_W;

endpackage

// File: rtl/pla_fsm_sequencer_onehot_check.sv
// One-hot legality check: flags a zero-hot or
// multi-hot state vector.
module onehot_check #(
  parameter int W = 7
) (
  input  logic [W-1:0] vec_i,
  output logic         is_zero,
  output logic         is_multi
);

  logic [W-1:0] low_clr;

  // Clearing the lowest set bit leaves zero only for one-hot or zero.
  assign low_clr  = vec_i & (vec_i - W'(1));
  assign is_zero  = (vec_i == '0);
  assign is_multi = (low_clr != '0);

endmodule

// File: rtl/pla_fsm_sequencer.sv
// Clocked wrapper that runs an external next-state PLA
// as a one-hot FSM with a valid/ready result stream.
module pla_fsm_sequencer
  import pla_seq_pkg::*;
#(
  parameter int STATE_W = P_STATE_W,
  parameter int SYM_W   = P_SYM_W,
  parameter int OUT_W   = P_OUT_W,
  parameter logic [STATE_W-1:0] RESET_STATE =
    STATE_W'(P_RESET_STATE),
  parameter int CNT_W   = P_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     restart,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SYM_W-1:0]         in_sym,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_sym,
  output logic                     out_err,
  output logic [STATE_W+SYM_W-1:0] pla_x,
  input  logic [STATE_W+OUT_W-1:0] pla_z,
  output logic [STATE_W-1:0]       state,
  output logic                     err_sticky,
  input  logic                     err_clr,
  output logic [CNT_W-1:0]         sym_count
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               valid_q, valid_d;
  logic [OUT_W-1:0]   sym_q, sym_d;
  logic               err_q, err_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [STATE_W-1:0] z_state;
  logic [OUT_W-1:0]   z_sym;
  logic               is_zero, is_multi, illegal;
  logic               accept;

  assign pla_x   = {state_q, in_sym};
  assign z_state = pla_z[OUT_W +: STATE_W];
  assign z_sym   = pla_z[OUT_W-1:0];

  onehot_check #(.W(STATE_W)) u_chk (
    .vec_i    (z_state),
    .is_zero  (is_zero),
    .is_multi (is_multi)
  );

  assign illegal = is_zero | is_multi;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RESET_STATE;
      valid_q  <= 1'b0;
      sym_q    <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      sym_q    <= sym_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    sym_d    = sym_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (err_clr) sticky_d = 1'b0;
    if (restart) begin
      state_d = RESET_STATE;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (accept) begin
      // Illegal next states never reach the state register.
      state_d = illegal ? RESET_STATE : z_state;
      sym_d   = z_sym;
      err_d   = illegal;
      valid_d = 1'b1;
      cnt_d   = cnt_q + CNT_W'(1);
      if (illegal) sticky_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    in_ready = rst_n && !restart && (!valid_q || out_ready);
    accept   = in_valid && in_ready;
  end

  assign out_valid  = valid_q;
  assign out_sym    = sym_q;
  assign out_err    = err_q;
  assign state      = state_q;
  assign err_sticky = sticky_q;
  assign sym_count  = cnt_q;

endmodule

// File: tb/tb_pla_fsm_sequencer.sv
// Randomized bench with a table-driven PLA and an
// index-based behavioural model of the sequencer.
module tb_pla_fsm_sequencer;
  import pla_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, restart, in_valid, in_ready;
  logic [1:0] in_sym;
  logic       out_valid, out_ready, out_err;
  logic [1:0] out_sym;
  logic [8:0] pla_x, pla_z;
  logic [6:0] state;
  logic       err_sticky, err_clr;
  logic [15:0] sym_count;

  logic [8:0] pla_tab [512];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  int          m_idx;
  bit          m_valid, m_err, m_sticky;
  logic [1:0]  m_sym;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  assign pla_z = pla_tab[pla_x];

  pla_fsm_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sym     (in_sym),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sym    (out_sym),
    .out_err    (out_err),
    .pla_x      (pla_x),
    .pla_z      (pla_z),
    .state      (state),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .sym_count  (sym_count)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] m_vec();
    return 7'(1) << m_idx;
  endfunction

  function automatic bit m_ready();
    return rst_n && !restart && (!m_valid || out_ready);
  endfunction

  // Reference model: state kept as a bit position.
  always @(posedge clk) begin
    bit acc;
    logic [8:0] z;
    logic [6:0] ns;
    acc = in_valid && m_ready();
    if (!rst_n) begin
      m_idx = 0; m_valid = 0; m_sym = 0;
      m_err = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      if (err_clr) m_sticky = 0;
      if (restart) begin
        m_idx = 0; m_valid = 0; m_cnt = 0;
      end else if (acc) begin
        z  = pla_tab[{m_vec(), in_sym}];
        ns = z[8:2];
        m_sym = z[1:0];
        m_valid = 1;
        m_cnt = (m_cnt + 1) % 65536;
        if ($countones(ns) != 1) begin
          m_idx = 0; m_err = 1; m_sticky = 1;
        end else begin
          m_err = 0;
          for (int i = 0; i < 7; i++)
            if (ns[i]) m_idx = i;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("state", 32'(state), 32'(m_vec()));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("sym_count", 32'(sym_count), m_cnt);
      chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      chk("pla_x", 32'(pla_x), 32'({m_vec(), in_sym}));
      if (m_valid) begin
        chk("out_sym", 32'(out_sym), 32'(m_sym));
        chk("out_err", 32'(out_err), 32'(m_err));
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      logic [6:0] s;
      if ($urandom_range(9) < 8)
        s = 7'(1) << $urandom_range(6);
      else
        s = 7'($urandom);
      pla_tab[i] = {s, 2'($urandom)};
    end
    rst_n = 0; restart = 0; in_valid = 1; in_sym = 0;
    out_ready = 0; err_clr = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'h01);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_count", 32'(sym_count), 32'h0);
    chk_en = 1;

    pla_tab[{7'b0000001, 2'b01}] = {7'b0000100, 2'b10};
    rst_n = 1; in_valid = 1; in_sym = 2'b01; out_ready = 1;
    @(negedge clk);
    chk("step_state", 32'(state), 32'h04);
    chk("step_sym", 32'(out_sym), 32'h2);
    chk("step_valid", 32'(out_valid), 32'h1);
    chk("step_count", 32'(sym_count), 32'h1);
    chk("step_plax", 32'(pla_x), 32'({7'b0000100, 2'b01}));

    pla_tab[{7'b0000100, 2'b11}] = {7'b0010000, 2'b11};
    in_sym = 2'b11; out_ready = 0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_ready", 32'(in_ready), 32'h0);
      chk("bp_sym", 32'(out_sym), 32'h2);
      chk("bp_state", 32'(state), 32'h04);
      chk("bp_count", 32'(sym_count), 32'h1);
    end
    out_ready = 1;
    @(negedge clk);
    chk("drain_count", 32'(sym_count), 32'h2);
    chk("drain_state", 32'(state), 32'h10);
    chk("drain_sym", 32'(out_sym), 32'h3);
    chk("drain_valid", 32'(out_valid), 32'h1);

    pla_tab[{7'b0010000, 2'b00}] = {7'b0000000, 2'b01};
    in_sym = 2'b00;
    @(negedge clk);
    chk("zh_state", 32'(state), 32'h01);
    chk("zh_err", 32'(out_err), 32'h1);
    chk("zh_sym", 32'(out_sym), 32'h1);
    chk("zh_sticky", 32'(err_sticky), 32'h1);
    pla_tab[{7'b0000001, 2'b00}] = {7'b0011000, 2'b10};
    @(negedge clk);
    chk("mh_state", 32'(state), 32'h01);
    chk("mh_err", 32'(out_err), 32'h1);
    chk("mh_sticky", 32'(err_sticky), 32'h1);
    in_valid = 0; err_clr = 1;
    @(negedge clk);
    chk("clr_sticky", 32'(err_sticky), 32'h0);
    chk("clr_valid", 32'(out_valid), 32'h0);
    err_clr = 0;

    pla_tab[{7'b0000001, 2'b10}] = {7'b0000011, 2'b00};
    pla_tab[{7'b0000001, 2'b11}] = {7'b0100000, 2'b00};
    in_valid = 1; in_sym = 2'b10;
    @(negedge clk);
    in_sym = 2'b11;
    @(negedge clk);
    chk("pre_rs_state", 32'(state), 32'h20);
    out_ready = 0; restart = 1;
    @(negedge clk);
    chk("rs_valid", 32'(out_valid), 32'h0);
    chk("rs_state", 32'(state), 32'h01);
    chk("rs_count", 32'(sym_count), 32'h0);
    chk("rs_sticky", 32'(err_sticky), 32'h1);
    chk("rs_ready", 32'(in_ready), 32'h0);
    restart = 0;

    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_sym    = 2'($urandom);
      out_ready = ($urandom_range(3) != 0);
      restart   = ($urandom_range(60) == 0);
      err_clr   = ($urandom_range(15) == 0);
      rst_n     = ($urandom_range(200) != 0);
      @(negedge clk);
    end

    rst_n = 1; err_clr = 0; restart = 1;
    @(negedge clk);
    restart = 0; in_valid = 1; out_ready = 1;
    repeat (65535) @(negedge clk);
    chk("wrap_full", 32'(sym_count), 32'hFFFF);
    @(negedge clk);
    chk("wrap_zero", 32'(sym_count), 32'h0);
    in_valid = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pla_fsm_sequencer.md
Name: pla_fsm_sequencer

Overview:
- Clocked controller that turns a purely combinational two-level next-state PLA into a running finite-state machine.
- Owns the one-hot state register and drives the PLA input vector as {state, symbol}.
- Captures the PLA output vector as {next_state, output symbol} and presents results on a valid/ready stream.
- Checks every PLA-produced next state for one-hot legality and recovers to the reset state on a violation.
- Sits between an upstream symbol source and downstream consumer; the PLA instance lives beside it, wired through pla_x/pla_z.

Parameters:
- STATE_W, 7: one-hot state width.
- SYM_W, 2: input symbol width.
- OUT_W, 2: output symbol width.
- RESET_STATE, 7'b000_0001: one-hot state loaded on reset, restart and error recovery.
- CNT_W, 16: accepted-symbol counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- restart  in  1  synchronous soft restart to RESET_STATE
- in_valid  in  1  upstream symbol valid
- in_ready  out  1  sequencer can accept a symbol
- in_sym  in  SYM_W  input symbol
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sym  out  OUT_W  PLA output symbol for the accepted input
- out_err  out  1  result came from an illegal next state
- pla_x  out  STATE_W+SYM_W  PLA inputs: [SYM_W-1:0]=in_sym, [SYM_W+:STATE_W]=state_q
- pla_z  in  STATE_W+OUT_W  PLA outputs: [OUT_W-1:0]=out symbol, [OUT_W+:STATE_W]=next state
- state  out  STATE_W  current state_q
- err_sticky  out  1  set on any illegal next state
- err_clr  in  1  clears err_sticky
- sym_count  out  CNT_W  accepted-symbol count, wraps

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n (sampled at the clk rising edge).
- Reset values: state_q=RESET_STATE, out_valid=0, out_sym=0, out_err=0, err_sticky=0, sym_count=0.
- pla_x is purely combinational from state_q and in_sym, independent of in_valid. pla_z is sampled only on accept.
- Control FSM is implicit in out_valid, giving two phases:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- in_ready = rst_n && !restart && (!out_valid || out_ready). This gives full throughput when downstream is ready.
- Accept = in_valid && in_ready. On accept edge:
  - state_q <= next state.
  - out_sym <= pla_z[OUT_W-1:0].
  - out_valid <= 1.
  - sym_count <= sym_count+1, wrapping from all-ones to 0.
- Latency: result visible one cycle after accept.
- Output holds while out_valid && !out_ready. out_sym/out_err are stable until the handshake completes.
- Output handshake with no new accept: out_valid <= 0.
- Simultaneous drain and accept in the same cycle: out_valid stays 1 and the new data is loaded.
- Illegal next state: pla_z state field is zero-hot or multi-hot.
  - state_q <= RESET_STATE.
  - out_sym is still captured from pla_z.
  - out_err <= 1 for that result.
  - err_sticky <= 1.
- err_clr clears err_sticky next edge. If a new illegal next state arrives in the same cycle, set wins.
- restart=1 has the following effects:
  - state_q <= RESET_STATE.
  - out_valid <= 0, so any pending result is dropped.
  - in_ready is 0, so no accept occurs.
  - sym_count <= 0.
  - err_sticky is unchanged.
- rst_n=0 overrides restart and everything else, including mid-handshake.
- state_q is never loaded from pla_z except on accept. Illegal values never reach state_q.

Decomposition:
- pla_seq_pkg holds:
  - Default widths.
  - RESET_STATE constant.
  - Field-slice localparams for pla_x/pla_z.
- One sub-module, onehot_check: combinational, STATE_W-wide. Outputs is_zero and is_multi; illegal = is_zero | is_multi.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → state=7'b0000001, out_valid=0, in_ready=0, sym_count=0.
- Basic step: state=0000001, in_sym=2'b01, bench PLA model returns pla_z={7'b0000100,2'b10}, out_ready=1 → next cycle state=0000100, out_sym=2'b10, out_valid=1, sym_count=1; pla_x reads {0000100,in_sym}.
- Backpressure: out_ready=0 for 4 cycles after one accept with in_valid held → in_ready=0, out_sym stable, state and sym_count unchanged; raise out_ready → pending result drains and new symbol accepted in the same cycle.
- Illegal next state:
  - PLA model returns state field 7'b0000000 → state=RESET_STATE, out_err=1 on that result, err_sticky=1.
  - Repeat with 7'b0011000 → same response.
  - err_clr then clears err_sticky.
- Restart mid-operation: out_valid=1, out_ready=0, state=0100000, assert restart one cycle → out_valid=0, state=0000001, sym_count=0, err_sticky retained, no accept that cycle.
- Counter wrap: preload via 65535 accepts (CNT_W=16) → next accept gives sym_count=0.
